// File: rtl/comm_pkg.sv
// Shared definitions for the UART command sender.
//   cmd_state_t : command FSM states
//   BAUD_DIV    : clk cycles per UART bit, shared by the sender and its UART core
//   cnt_w()     : counter width helper that never returns zero
package comm_pkg;

  typedef enum logic [1:0] {IDLE, XMIT, WAIT_TX, WAIT_RESP} cmd_state_t;

  localparam int BAUD_DIV = 8;

  // Width needed to hold values 0..n-1; a 1-bit minimum keeps degenerate
  // parameter choices (n <= 1) from producing zero-width vectors.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comm_cmd_sender_uart.sv
// 8N1 UART core: one transmitter, one receiver, shared baud divisor.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   trmt            1-cycle strobe: start sending tx_data (ignored while sending)
//   tx_data[7:0]    byte to send, LSB first
//   tx_done         1-cycle pulse after the stop bit has been driven
//   tx              serial out, idle high
//   rx              serial in (asynchronous, synchronised here)
//   rx_rdy          set when a byte is received; cleared by clr_rx_rdy or a new start bit
//   rx_data[7:0]    last byte received, stable until the next byte completes
//   clr_rx_rdy      clears rx_rdy (a completing byte in the same cycle wins)
module comm_cmd_sender_uart
  import comm_pkg::*;
#(
  parameter int BAUD = BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rx_rdy
);

  localparam int BAUD_W = cnt_w(BAUD);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD / 2);

  logic              tx_busy;
  logic [BAUD_W-1:0] tx_baud;
  logic [3:0]        tx_bits;
  logic [9:0]        tx_shift;

  // The line is always the LSB of the frame register; it resets to all ones so
  // an aborted frame leaves the line high immediately.
  assign tx = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !tx_busy) begin
        tx_busy  <= 1'b1;
        tx_baud  <= '0;
        tx_bits  <= '0;
        tx_shift <= {1'b1, tx_data, 1'b0};
      end else if (tx_busy) begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud  <= '0;
          tx_shift <= {1'b1, tx_shift[9:1]};
          if (tx_bits == 4'd9) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            tx_bits <= tx_bits + 4'd1;
          end
        end else begin
          tx_baud <= tx_baud + 1'b1;
        end
      end
    end
  end

  logic [1:0]        rx_sync;
  logic              rx_s;
  logic              rx_busy;
  logic [BAUD_W-1:0] rx_baud;
  logic [3:0]        rx_bits;
  logic [7:0]        rx_shift;

  assign rx_s = rx_sync[1];

  // Start bit detection preloads the baud counter to half a bit so every
  // subsequent sample lands mid-bit. Bit index 0 is the start bit, 1..8 data,
  // 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (clr_rx_rdy) begin
        rx_rdy <= 1'b0;
      end
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_baud <= BAUD_HALF;
          rx_bits <= '0;
          rx_rdy  <= 1'b0;
        end
      end else if (rx_baud == BAUD_LAST) begin
        rx_baud <= '0;
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits == 4'd0) begin
          // Line back high mid start bit: a glitch, not a frame.
          if (rx_s) begin
            rx_busy <= 1'b0;
          end
        end else if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_data <= rx_shift;
          rx_rdy  <= 1'b1;
        end else begin
          rx_shift <= {rx_s, rx_shift[7:1]};
        end
      end else begin
        rx_baud <= rx_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comm_cmd_sender.sv
// UART command transmitter with response tracking. Latches a NUM_BYTES-wide
// command, sends it byte by byte (MSB or LSB byte first), then waits for a
// one-byte response, flagging a sticky timeout if none arrives.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd             command word, sampled when send_cmd is accepted
//   send_cmd        request to send cmd (ignored while busy)
//   RX / TX         serial in / serial out (TX idle high)
//   clr_resp_rdy    clears resp_rdy
//   busy            command transmission in progress (XMIT / WAIT_TX)
//   cmd_sent        last byte done; held until the next accepted send_cmd
//   resp_rdy, resp  response byte valid / response byte
//   resp_timeout    sticky: no response within TIMEOUT_CYC cycles
module comm_cmd_sender
  import comm_pkg::*;
#(
  parameter int NUM_BYTES   = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] cmd,
  input  logic                   send_cmd,
  input  logic                   RX,
  input  logic                   clr_resp_rdy,
  output logic                   TX,
  output logic                   busy,
  output logic                   cmd_sent,
  output logic                   resp_rdy,
  output logic [7:0]             resp,
  output logic                   resp_timeout
);

  localparam int CMD_W = 8 * NUM_BYTES;
  localparam int CNT_W = cnt_w(NUM_BYTES);
  localparam int TMO_W = cnt_w(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  cmd_state_t       state, nxt_state;
  logic [CMD_W-1:0] shreg;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             resp_rdy_q;
  logic             resp_rise;
  logic             trmt;
  logic             tx_done;
  logic [7:0]       tx_byte;
  logic             accept;
  logic             advance;
  logic             finish;
  logic             tmo_hit;

  // The outgoing byte always sits at the same end of the shift register.
  assign tx_byte   = MSB_FIRST ? shreg[CMD_W-1 -: 8] : shreg[7:0];
  assign resp_rise = resp_rdy & ~resp_rdy_q;
  assign busy      = (state == XMIT) || (state == WAIT_TX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    trmt      = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (send_cmd) begin
          accept    = 1'b1;
          nxt_state = XMIT;
        end
      end
      XMIT: begin
        trmt      = 1'b1;
        nxt_state = WAIT_TX;
      end
      WAIT_TX: begin
        // send_cmd is deliberately not looked at here, including on the
        // final tx_done.
        if (tx_done) begin
          if (byte_cnt == LAST_BYTE) begin
            finish    = 1'b1;
            nxt_state = WAIT_RESP;
          end else begin
            advance   = 1'b1;
            nxt_state = XMIT;
          end
        end
      end
      WAIT_RESP: begin
        // A new command takes priority; a response on the last count cycle
        // beats the timeout.
        if (send_cmd) begin
          accept    = 1'b1;
          nxt_state = XMIT;
        end else if (resp_rise || (TIMEOUT_CYC == 0)) begin
          nxt_state = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      cmd_sent     <= 1'b0;
      resp_timeout <= 1'b0;
      resp_rdy_q   <= 1'b0;
    end else begin
      resp_rdy_q <= resp_rdy;
      if (accept) begin
        shreg        <= cmd;
        byte_cnt     <= '0;
        cmd_sent     <= 1'b0;
        resp_timeout <= 1'b0;
      end else if (advance) begin
        shreg    <= MSB_FIRST ? (shreg << 8) : (shreg >> 8);
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (finish) begin
        cmd_sent <= 1'b1;
      end
      if (tmo_hit) begin
        resp_timeout <= 1'b1;
      end
      // Held at zero outside WAIT_RESP, so it always starts from zero there.
      if (state == WAIT_RESP) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  comm_cmd_sender_uart #(
    .BAUD(BAUD_DIV)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .trmt      (trmt),
    .tx_data   (tx_byte),
    .tx_done   (tx_done),
    .tx        (TX),
    .rx        (RX),
    .rx_rdy    (resp_rdy),
    .rx_data   (resp),
    .clr_rx_rdy(clr_resp_rdy)
  );

endmodule

// File: tb/tb_comm_cmd_sender.sv
// Directed bench for comm_cmd_sender: two instances (MSB-first and LSB-first,
// 3-byte commands, 100-cycle timeout) share all inputs. Expected TX bytes are
// queued when a command is issued and compared by serial frame monitors.
module tb_comm_cmd_sender;
  import comm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] cmd = '0;
  logic        send_cmd = 1'b0;
  logic        rx = 1'b1;
  logic        clr_resp_rdy = 1'b0;

  logic       tx_m, busy_m, sent_m, rrdy_m, tmo_m;
  logic [7:0] resp_m;
  logic       tx_l, busy_l, sent_l, rrdy_l, tmo_l;
  logic [7:0] resp_l;

  int checks = 0;
  int errors = 0;
  int frames_m = 0;
  int frames_l = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  always #5 clk = ~clk;

  comm_cmd_sender #(.NUM_BYTES(3), .MSB_FIRST(1'b1), .TIMEOUT_CYC(100)) dut_m (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .send_cmd(send_cmd), .RX(rx),
    .clr_resp_rdy(clr_resp_rdy), .TX(tx_m), .busy(busy_m), .cmd_sent(sent_m),
    .resp_rdy(rrdy_m), .resp(resp_m), .resp_timeout(tmo_m)
  );

  comm_cmd_sender #(.NUM_BYTES(3), .MSB_FIRST(1'b0), .TIMEOUT_CYC(100)) dut_l (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .send_cmd(send_cmd), .RX(rx),
    .clr_resp_rdy(clr_resp_rdy), .TX(tx_l), .busy(busy_l), .cmd_sent(sent_l),
    .resp_rdy(rrdy_l), .resp(resp_l), .resp_timeout(tmo_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode one frame whose start bit has just begun; ok=0 if reset interrupts it.
  task automatic grab(input bit sel, output logic [7:0] b, output bit ok);
    logic s;
    ok = 1'b1;
    b  = '0;
    repeat (BAUD_DIV / 2) @(posedge clk);
    #1;
    s = sel ? tx_l : tx_m;
    if (s !== 1'b0 || rst_n !== 1'b1) ok = 1'b0;
    for (int i = 0; i < 9 && ok; i++) begin
      repeat (BAUD_DIV) @(posedge clk);
      #1;
      s = sel ? tx_l : tx_m;
      if (rst_n !== 1'b1) ok = 1'b0;
      else if (i < 8) b[i] = s;
      else chk(sel ? "stop_bit_l" : "stop_bit_m", 32'(s), 32'd1);
    end
  endtask

  always begin : mon_m
    logic [7:0] b;
    bit ok;
    logic [31:0] e;
    @(negedge tx_m);
    grab(1'b0, b, ok);
    if (ok) begin
      frames_m++;
      e = 32'h100;
      if (exp_m.size() != 0) e = 32'(exp_m.pop_front());
      chk("frame_m", 32'(b), e);
    end
  end

  always begin : mon_l
    logic [7:0] b;
    bit ok;
    logic [31:0] e;
    @(negedge tx_l);
    grab(1'b1, b, ok);
    if (ok) begin
      frames_l++;
      e = 32'h100;
      if (exp_l.size() != 0) e = 32'(exp_l.pop_front());
      chk("frame_l", 32'(b), e);
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_tx_m"},   32'(tx_m),   32'd1);
    chk({tag, "_busy_m"}, 32'(busy_m), 32'd0);
    chk({tag, "_sent_m"}, 32'(sent_m), 32'd0);
    chk({tag, "_rrdy_m"}, 32'(rrdy_m), 32'd0);
    chk({tag, "_resp_m"}, 32'(resp_m), 32'd0);
    chk({tag, "_tmo_m"},  32'(tmo_m),  32'd0);
    chk({tag, "_tx_l"},   32'(tx_l),   32'd1);
    chk({tag, "_busy_l"}, 32'(busy_l), 32'd0);
    chk({tag, "_sent_l"}, 32'(sent_l), 32'd0);
    chk({tag, "_rrdy_l"}, 32'(rrdy_l), 32'd0);
    chk({tag, "_resp_l"}, 32'(resp_l), 32'd0);
    chk({tag, "_tmo_l"},  32'(tmo_l),  32'd0);
  endtask

  // Issue a command for one cycle and queue the frames each instance must send.
  task automatic send(input logic [23:0] c);
    cmd      = c;
    send_cmd = 1'b1;
    for (int i = 2; i >= 0; i--) exp_m.push_back(c[8*i +: 8]);
    for (int i = 0; i < 3; i++)  exp_l.push_back(c[8*i +: 8]);
    tick();
    send_cmd = 1'b0;
  endtask

  // Wait for cmd_sent; it must rise one cycle after the last tx_done, with busy
  // falling in the same cycle.
  task automatic wait_sent(input string tag);
    logic pd, pb;
    int n;
    pd = dut_m.u_uart.tx_done;
    pb = busy_m;
    n  = 0;
    while (sent_m !== 1'b1 && n < 3000) begin
      pd = dut_m.u_uart.tx_done;
      pb = busy_m;
      tick();
      n++;
    end
    chk({tag, "_sent_in_time"}, 32'(n < 3000), 32'd1);
    chk({tag, "_txdone_prev"},  32'(pd),       32'd1);
    chk({tag, "_busy_prev"},    32'(pb),       32'd1);
    chk({tag, "_busy_now"},     32'(busy_m),   32'd0);
    chk({tag, "_sent_l"},       32'(sent_l),   32'd1);
    chk({tag, "_busy_l"},       32'(busy_l),   32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = fr[i];
      repeat (BAUD_DIV - 1) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk_rst("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // MSB/LSB ordering; cmd changes and a second request during the transfer.
    send(24'hA55A3C);
    chk("trmt_latency", 32'(dut_m.trmt), 32'd1);
    chk("busy_m_on_accept", 32'(busy_m), 32'd1);
    cmd = 24'hFFFFFF;
    tick();
    chk("trmt_one_cycle", 32'(dut_m.trmt), 32'd0);
    n = 0;
    while (exp_m.size() > 2 && n < 2000) begin tick(); n++; end
    chk("first_frame_in_time", 32'(n < 2000), 32'd1);
    repeat (BAUD_DIV * 3) tick();
    cmd      = 24'h123456;
    send_cmd = 1'b1;
    tick();
    send_cmd = 1'b0;
    chk("busy_during_ignored_send", 32'(busy_m), 32'd1);
    wait_sent("t1");
    chk("t1_queue_m", 32'(exp_m.size()), 32'd0);
    chk("t1_queue_l", 32'(exp_l.size()), 32'd0);
    chk("t1_frames_m", 32'(frames_m), 32'd3);
    chk("t1_frames_l", 32'(frames_l), 32'd3);

    // No response: timeout exactly 100 cycles after cmd_sent rises.
    n = 0;
    while (tmo_m !== 1'b1 && n < 150) begin tick(); n++; end
    chk("timeout_cycles_m", 32'(n), 32'd100);
    chk("timeout_l", 32'(tmo_l), 32'd1);
    chk("frames_m_after_timeout", 32'(frames_m), 32'd3);

    // New command clears cmd_sent and resp_timeout on accept.
    send(24'h123456);
    chk("t3_sent_cleared", 32'(sent_m), 32'd0);
    chk("t3_tmo_cleared_m", 32'(tmo_m), 32'd0);
    chk("t3_tmo_cleared_l", 32'(tmo_l), 32'd0);
    wait_sent("t3");
    chk("t3_queue_m", 32'(exp_m.size()), 32'd0);
    chk("t3_queue_l", 32'(exp_l.size()), 32'd0);

    // Response C3 arrives before the timeout.
    send_rx(8'hC3);
    repeat (4) tick();
    chk("resp_rdy_m", 32'(rrdy_m), 32'd1);
    chk("resp_m", 32'(resp_m), 32'hC3);
    chk("resp_rdy_l", 32'(rrdy_l), 32'd1);
    chk("resp_l", 32'(resp_l), 32'hC3);
    repeat (40) tick();
    chk("no_timeout_m", 32'(tmo_m), 32'd0);
    chk("no_timeout_l", 32'(tmo_l), 32'd0);
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    chk("resp_rdy_clr_m", 32'(rrdy_m), 32'd0);
    chk("resp_rdy_clr_l", 32'(rrdy_l), 32'd0);

    // Reset in the middle of byte 2.
    send(24'hA55A3C);
    n = 0;
    while (exp_m.size() > 2 && n < 2000) begin tick(); n++; end
    chk("t6_first_frame_in_time", 32'(n < 2000), 32'd1);
    repeat (BAUD_DIV * 3) tick();
    rst_n = 1'b0;
    #1;
    chk_rst("midreset");
    exp_m.delete();
    exp_l.delete();
    repeat (BAUD_DIV * 2 + 4) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t6_frames_m", 32'(frames_m), 32'd7);
    chk("t6_frames_l", 32'(frames_l), 32'd7);
    send(24'hA55A3C);
    wait_sent("t6");
    chk("t6_queue_m", 32'(exp_m.size()), 32'd0);
    chk("t6_queue_l", 32'(exp_l.size()), 32'd0);
    chk("t6_frames_m_end", 32'(frames_m), 32'd10);
    chk("t6_frames_l_end", 32'(frames_l), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
